// File: rtl/ysyx_24100029_hs_fifo.sv
// Synchronous valid/ready FIFO with occupancy, almost-full/empty flags and flush.
// OUT_REG=1 adds a head register (counted in level) fed from the array or bypassed from in_data.
module ysyx_24100029_hs_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int AFULL_TH   = FIFO_DEPTH - 1,
  parameter int AEMPTY_TH  = 1,
  parameter int OUT_REG    = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       clr,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [DATA_WIDTH-1:0]                      in_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [DATA_WIDTH-1:0]                      out_data,
  output logic [$clog2(FIFO_DEPTH+OUT_REG+1)-1:0]    level,
  output logic                                       almost_full,
  output logic                                       almost_empty
);

  localparam int CAP = FIFO_DEPTH + OUT_REG;
  localparam int LW  = $clog2(CAP + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] CAP_L    = LW'(CAP);
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_TH);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_TH);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (AFULL_TH > CAP) begin : g_bad_afull
    $error("AFULL_TH must not exceed capacity");
  end
  if (AEMPTY_TH >= CAP) begin : g_bad_aempty
    $error("AEMPTY_TH must be below capacity");
  end

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  push, pop;
  logic                  arr_wr, arr_rd;

  // in_ready comes from registered state only, so a full FIFO never accepts on a same-cycle pop.
  assign in_ready     = (level_q != CAP_L);
  assign push         = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign level        = level_q;
  assign almost_full  = (level_q >= AFULL_L);
  assign almost_empty = (level_q <= AEMPTY_L);

  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !pop) level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      if (arr_wr) wr_ptr_d = wr_ptr_q + PW'(1);
      if (arr_rd) rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is never cleared; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (arr_wr && !clr && !rst) mem_q[wr_ptr_q] <= in_data;
  end

  if (OUT_REG == 0) begin : g_comb_out
    assign arr_wr    = push;
    assign arr_rd    = pop;
    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
  end else begin : g_reg_out
    logic                  ovld_q, ovld_d;
    logic [DATA_WIDTH-1:0] odat_q, odat_d;
    logic                  arr_empty, load;

    // The head register is empty only when the array is empty as well.
    assign arr_empty = (level_q == LW'(ovld_q));
    assign load      = !ovld_q || out_ready;
    assign arr_rd    = load && !arr_empty;
    assign arr_wr    = push && !(load && arr_empty);
    assign out_valid = ovld_q;
    assign out_data  = odat_q;

    always_comb begin
      ovld_d = ovld_q;
      odat_d = odat_q;
      if (clr) begin
        ovld_d = 1'b0;
      end else if (load) begin
        if (!arr_empty) begin
          ovld_d = 1'b1;
          odat_d = mem_q[rd_ptr_q];
        end else begin
          ovld_d = push;
          if (push) odat_d = in_data;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) ovld_q <= 1'b0;
      else     ovld_q <= ovld_d;
    end

    always_ff @(posedge clk) begin
      odat_q <= odat_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_hs_fifo.sv
// Directed bench for ysyx_24100029_hs_fifo: one instance with OUT_REG=0, one with OUT_REG=1.
module tb_ysyx_24100029_hs_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        clr0, iv0, or0, ir0, ov0, af0, ae0;
  logic [31:0] id0, od0;
  logic [2:0]  lv0;
  logic        clr1, iv1, or1, ir1, ov1, af1, ae1;
  logic [31:0] id1, od1;
  logic [2:0]  lv1;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_24100029_hs_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr0),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .level(lv0), .almost_full(af0), .almost_empty(ae0)
  );

  ysyx_24100029_hs_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .level(lv1), .almost_full(af1), .almost_empty(ae1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fill_v [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] drn0_v [4] = '{32'h22, 32'h33, 32'h44, 32'h55};
  logic [31:0] bp_v   [4] = '{32'h5A, 32'h3C, 32'h77, 32'h88};
  logic [31:0] drn1_v [5] = '{32'hA5, 32'h5A, 32'h3C, 32'h77, 32'h88};

  initial begin
    clr0 = 0; iv0 = 0; or0 = 0; id0 = 0;
    clr1 = 0; iv1 = 0; or1 = 0; id1 = 0;
    tick(); tick();
    rst = 0;

    // Reset state
    chk("rst_lv0", lv0, 0);  chk("rst_ov0", ov0, 0);  chk("rst_ir0", ir0, 1);
    chk("rst_ae0", ae0, 1);  chk("rst_af0", af0, 0);
    chk("rst_lv1", lv1, 0);  chk("rst_ov1", ov1, 0);  chk("rst_ir1", ir1, 1);
    chk("rst_ae1", ae1, 1);  chk("rst_af1", af1, 0);

    // Fill DUT0 with out_ready low
    iv0 = 1;
    for (int i = 0; i < 4; i++) begin
      id0 = fill_v[i];
      tick();
      chk("fill_lv", lv0, i + 1);
      chk("fill_af", af0, (i + 1) >= 3);
    end
    chk("full_ir", ir0, 0);

    // Full with push and pop offered: pop happens, push refused
    id0 = 32'h55; or0 = 1;
    chk("fullpp_ir", ir0, 0);
    chk("fullpp_ov", ov0, 1);
    chk("fullpp_od", od0, 32'h11);
    tick();
    chk("fullpp_lv", lv0, 3);
    chk("fullpp_ir_after", ir0, 1);
    or0 = 0;
    tick();
    chk("repush_lv", lv0, 4);
    iv0 = 0; or0 = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain0_ov", ov0, 1);
      chk("drain0_od", od0, drn0_v[i]);
      tick();
    end
    chk("drain0_end_ov", ov0, 0);
    chk("drain0_end_ae", ae0, 1);
    chk("drain0_end_lv", lv0, 0);
    or0 = 0;

    // Streaming on both instances, covers pointer wrap and the bypass path
    iv0 = 1; or0 = 1; iv1 = 1; or1 = 1;
    for (int i = 0; i < 20; i++) begin
      id0 = i; id1 = i;
      chk("strm_lv0", lv0, (i == 0) ? 0 : 1);
      chk("strm_lv1", lv1, (i == 0) ? 0 : 1);
      if (i > 0) begin
        chk("strm_od0", od0, i - 1);
        chk("strm_od1", od1, i - 1);
      end
      tick();
    end
    iv0 = 0; iv1 = 0;
    chk("strm_last_od0", od0, 19);
    chk("strm_last_od1", od1, 19);
    tick();
    chk("strm_end_lv0", lv0, 0);
    chk("strm_end_lv1", lv1, 0);
    or0 = 0; or1 = 0;

    // DUT1 backpressure: head held stable, fill to capacity 5
    iv1 = 1; id1 = 32'hA5;
    tick();
    iv1 = 0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_ov", ov1, 1);
      chk("bp_od", od1, 32'hA5);
      tick();
    end
    iv1 = 1;
    for (int j = 0; j < 4; j++) begin
      id1 = bp_v[j];
      tick();
      chk("bp_lv", lv1, j + 2);
      chk("bp_hold_od", od1, 32'hA5);
    end
    chk("bp_full_ir", ir1, 0);
    chk("bp_full_af", af1, 1);
    iv1 = 0; or1 = 1;
    for (int i = 0; i < 5; i++) begin
      chk("drain1_od", od1, drn1_v[i]);
      tick();
    end
    chk("drain1_end_ov", ov1, 0);
    chk("drain1_end_lv", lv1, 0);
    or1 = 0;

    // clr on DUT0 at level 3 with push and pop offered
    iv0 = 1;
    for (int i = 0; i < 3; i++) begin
      id0 = 32'hA1 + i;
      tick();
    end
    chk("preclr_lv", lv0, 3);
    clr0 = 1; id0 = 32'hEE; or0 = 1;
    tick();
    clr0 = 0; iv0 = 0; or0 = 0;
    chk("clr_lv", lv0, 0);
    chk("clr_ov", ov0, 0);
    chk("clr_ir", ir0, 1);
    chk("clr_ae", ae0, 1);
    iv0 = 1; id0 = 32'h99;
    tick();
    iv0 = 0;
    chk("postclr_ov", ov0, 1);
    chk("postclr_od", od0, 32'h99);
    chk("postclr_lv", lv0, 1);
    or0 = 1;
    tick();
    chk("postclr_drain_lv", lv0, 0);
    or0 = 0;

    // rst together with clr on DUT1 mid-burst
    iv1 = 1;
    id1 = 32'h11; tick();
    id1 = 32'h22; tick();
    rst = 1; clr1 = 1; id1 = 32'h33;
    tick();
    rst = 0; clr1 = 0; id1 = 32'h42;
    chk("rstclr_lv", lv1, 0);
    chk("rstclr_ov", ov1, 0);
    chk("rstclr_ir", ir1, 1);
    tick();
    iv1 = 0;
    chk("postrst_lv", lv1, 1);
    chk("postrst_ov", ov1, 1);
    chk("postrst_od", od1, 32'h42);
    or1 = 1;
    tick();
    chk("postrst_drain_ov", ov1, 0);
    or1 = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24100029_hs_fifo.md
Name: ysyx_24100029_hs_fifo

Overview:
- Parametrised synchronous FIFO with valid/ready handshakes on both sides.
- Adds almost-full/almost-empty thresholds, an occupancy output, a synchronous flush, and an optional registered output stage (OUT_REG).
- Sits between pipeline stages and between the LSU and the bus bridge, decoupling producer and consumer.
- Only accepted transfers change occupancy; simultaneous push and pop keep it constant.

Parameters:
- DATA_WIDTH, 32: payload width in bits.
- FIFO_DEPTH, 4: storage-array entries. Must be a power of 2 and ≥ 2.
- AFULL_TH, FIFO_DEPTH-1: almost_full asserts when level ≥ AFULL_TH.
- AEMPTY_TH, 1: almost_empty asserts when level ≤ AEMPTY_TH.
- OUT_REG, 0: 0 = output read combinationally from the array; 1 = output driven from a dedicated register stage.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous flush; same effect as rst on state.
- in_valid  in  1  producer has data.
- in_ready  out  1  FIFO can accept data.
- in_data  in  DATA_WIDTH  write payload.
- out_valid  out  1  head entry is available.
- out_ready  in  1  consumer takes the head entry.
- out_data  out  DATA_WIDTH  head payload.
- level  out  $clog2(FIFO_DEPTH+OUT_REG+1)  entries currently held.
- almost_full  out  1  level ≥ AFULL_TH.
- almost_empty  out  1  level ≤ AEMPTY_TH.

Behaviour:
- Capacity: CAP = FIFO_DEPTH + OUT_REG. The output register, when present, counts as one entry in level.
- Events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Only push and pop events modify state.
- Level update:
  - push only: level + 1.
  - pop only: level − 1.
  - both or neither: level unchanged.
  - level never exceeds CAP and never goes below 0.
- Handshake flags:
  - in_ready = (level != CAP), registered-state-derived only. It never depends on out_ready, so there is no full-bypass path.
  - out_valid = (level != 0) for OUT_REG=0. For OUT_REG=1 it equals the output-stage valid bit.
- Pointers: wr_ptr and rd_ptr are $clog2(FIFO_DEPTH) bits wide and wrap naturally from FIFO_DEPTH-1 to 0.
- OUT_REG=0:
  - out_data = mem[rd_ptr].
  - Write-to-out_valid latency is 1 cycle.
  - A push into an empty FIFO is not visible in the same cycle (no fall-through).
- OUT_REG=1:
  - The output stage loads from the array, or directly from in_data when the array is empty, whenever the stage is empty or is being popped.
  - Write-to-out_valid latency is 1 cycle.
  - out_data is stable while out_valid=1 and out_ready=0.
  - Ordering is strictly FIFO across the bypass path.
- Stability: with out_valid=1 and out_ready=0, out_data must not change.
- Full with in_valid and out_ready both high: the pop occurs and the push is refused (in_ready=0 that cycle). The next cycle has level = CAP−1 and in_ready=1.
- Empty with push: next cycle has level=1 and out_valid=1. No pop is possible in the push cycle.
- Priority: rst > clr > normal operation. A push or pop coinciding with clr is discarded.
- Reset/clr values:
  - level=0, pointers=0, output-stage valid=0.
  - out_valid=0, in_ready=1.
  - almost_empty=1 (since AEMPTY_TH ≥ 0).
  - almost_full=0 (unless AFULL_TH=0).
  - out_data is don't-care but must not be X-propagated into control logic.
  - Array contents are not cleared.
- Reset mid-burst: all held data is lost; in_ready=1 on the first cycle after reset deasserts.
- Parameter checking: elaboration-time assertion fails when FIFO_DEPTH is not a power of 2, or when AFULL_TH > CAP, or when AEMPTY_TH ≥ CAP.

Test Plan:
- Fill/drain, DEPTH=4, OUT_REG=0: push 0x11,0x22,0x33,0x44 with out_ready=0.
  - Expect level to step 1,2,3,4; in_ready=0 after the 4th push; almost_full high from level 3.
  - Then out_ready=1: pops return 0x11,0x22,0x33,0x44 in order; out_valid=0 and almost_empty=1 at the end.
- Full with simultaneous push+pop: at level 4, drive in_valid=1 (0x55) and out_ready=1.
  - Expect 0x11 popped, 0x55 rejected, level=3.
  - Next cycle push 0x55 is accepted; the final drain order ends with 0x55.
- Steady streaming: in_valid=out_ready=1 for 20 cycles with data 0..19.
  - Expect level constant, every value out exactly once in order.
  - Covers wrap-around of both pointers (5 wraps at DEPTH=4).
- Backpressure stability, OUT_REG=1: push 0xA5, hold out_ready=0 for 5 cycles.
  - Expect out_data=0xA5 and out_valid=1 throughout.
  - Then push 0x5A,0x3C,0x77,0x88: level reaches 5=CAP, then in_ready=0.
- clr mid-operation: at level 3, assert clr together with in_valid and out_ready.
  - Expect next cycle level=0, out_valid=0, in_ready=1, and no entry from that cycle surviving.
  - A subsequent push of 0x99 is the next value popped.
- rst over clr: assert rst and clr together mid-burst.
  - Expect the same post-reset values.
  - Deassert rst and push immediately: accepted in the first cycle after reset.
